// File: rtl/ib_uart_bridge.sv
// rtl/ib_uart_bridge.sv - host UART <-> IB expander byte bridge with one FIFO per direction
// Four-phase expander handshakes; all asynchronous inputs pass through 2-flop synchronisers.

module ib_uart_bridge_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wptr, r_rptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_push, w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // a push into a full FIFO is taken only when the head leaves in the same cycle
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end
endmodule

module ib_uart_bridge #(
  parameter int CLKS_PER_BIT = 833,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic       o_uart_tx,
  output logic [7:0] o_tx_data,
  output logic       o_tx_data_available,
  input  logic       i_tx_data_ack_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_data_available,
  output logic       o_tx_ack,
  output logic       o_rx_overrun,
  output logic       o_frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LP_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LP_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
  typedef enum logic [1:0] {F_OFFER, F_WAIT_ACK, F_WAIT_REL} feed_state_t;
  typedef enum logic {C_IDLE, C_ACKED} coll_state_t;

  logic r_rx_meta, r_rx_sync, r_rx_prev;
  logic r_ack_meta, r_ack_sync, r_avail_meta, r_avail_sync;

  uart_state_t r_rx_state, r_tx_state;
  feed_state_t r_feed_state;
  coll_state_t r_coll_state;
  logic [CW-1:0] r_rx_cnt, r_tx_cnt;
  logic [2:0]    r_rx_bit, r_tx_bit;
  logic [7:0]    r_rx_shift, r_tx_shift;

  logic       w_h2m_push, w_h2m_pop, w_h2m_full, w_h2m_empty;
  logic       w_m2h_push, w_m2h_pop, w_m2h_full, w_m2h_empty, w_tx_done;
  logic [7:0] w_h2m_rdata, w_m2h_rdata;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      {r_rx_meta, r_rx_sync, r_rx_prev} <= 3'b111;
      {r_ack_meta, r_ack_sync}          <= 2'b11;
      {r_avail_meta, r_avail_sync}      <= 2'b00;
    end else begin
      {r_rx_meta, r_rx_sync, r_rx_prev} <= {i_uart_rx, r_rx_meta, r_rx_sync};
      {r_ack_meta, r_ack_sync}          <= {i_tx_data_ack_n, r_ack_meta};
      {r_avail_meta, r_avail_sync}      <= {i_rx_data_available, r_avail_meta};
    end
  end

  assign w_h2m_push = (r_rx_state == U_STOP) && (r_rx_cnt == LP_BIT_LAST) && r_rx_sync;
  assign w_h2m_pop  = (r_feed_state == F_OFFER) && !w_h2m_empty;

  ib_uart_bridge_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_h2m (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(w_h2m_push), .i_wdata(r_rx_shift),
    .i_pop(w_h2m_pop), .o_rdata(w_h2m_rdata), .o_full(w_h2m_full), .o_empty(w_h2m_empty)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_state   <= U_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      o_rx_overrun <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      case (r_rx_state)
        U_IDLE: if (r_rx_prev && !r_rx_sync) begin
          r_rx_state <= U_START;
          r_rx_cnt   <= '0;
        end
        U_START: if (r_rx_cnt == LP_HALF_LAST) begin
          r_rx_cnt   <= '0;
          r_rx_bit   <= '0;
          r_rx_state <= r_rx_sync ? U_IDLE : U_DATA;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        U_DATA: if (r_rx_cnt == LP_BIT_LAST) begin
          r_rx_cnt   <= '0;
          r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) r_rx_state <= U_STOP;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        U_STOP: if (r_rx_cnt == LP_BIT_LAST) begin
          r_rx_cnt   <= '0;
          r_rx_state <= U_IDLE;
          if (!r_rx_sync) o_frame_err <= 1'b1;
          else if (w_h2m_full && !w_h2m_pop) o_rx_overrun <= 1'b1;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        default: r_rx_state <= U_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_feed_state        <= F_OFFER;
      o_tx_data           <= 8'hFF;
      o_tx_data_available <= 1'b0;
    end else begin
      case (r_feed_state)
        F_OFFER: if (!w_h2m_empty) begin
          o_tx_data           <= w_h2m_rdata;
          o_tx_data_available <= 1'b1;
          r_feed_state        <= F_WAIT_ACK;
        end
        F_WAIT_ACK: if (!r_ack_sync) begin
          o_tx_data_available <= 1'b0;
          r_feed_state        <= F_WAIT_REL;
        end
        F_WAIT_REL: if (r_ack_sync) r_feed_state <= F_OFFER;
        default: r_feed_state <= F_OFFER;
      endcase
    end
  end

  // withholding tx_ack while full stalls the meter instead of losing its byte
  assign w_m2h_push = (r_coll_state == C_IDLE) && r_avail_sync && !w_m2h_full;
  assign w_tx_done  = (r_tx_state == U_STOP) && (r_tx_cnt == LP_BIT_LAST);
  assign w_m2h_pop  = ((r_tx_state == U_IDLE) || w_tx_done) && !w_m2h_empty;

  ib_uart_bridge_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_m2h (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(w_m2h_push), .i_wdata(i_rx_data),
    .i_pop(w_m2h_pop), .o_rdata(w_m2h_rdata), .o_full(w_m2h_full), .o_empty(w_m2h_empty)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_coll_state <= C_IDLE;
      o_tx_ack     <= 1'b0;
    end else begin
      case (r_coll_state)
        C_IDLE: if (w_m2h_push) begin
          o_tx_ack     <= 1'b1;
          r_coll_state <= C_ACKED;
        end
        C_ACKED: if (!r_avail_sync) begin
          o_tx_ack     <= 1'b0;
          r_coll_state <= C_IDLE;
        end
        default: r_coll_state <= C_IDLE;
      endcase
    end
  end

  // popping at the end of the stop bit chains frames with no idle gap
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tx_state <= U_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      o_uart_tx  <= 1'b1;
    end else if (w_m2h_pop) begin
      r_tx_shift <= w_m2h_rdata;
      r_tx_cnt   <= '0;
      r_tx_state <= U_START;
      o_uart_tx  <= 1'b0;
    end else begin
      case (r_tx_state)
        U_IDLE: r_tx_cnt <= '0;
        U_START: if (r_tx_cnt == LP_BIT_LAST) begin
          r_tx_cnt   <= '0;
          r_tx_bit   <= '0;
          o_uart_tx  <= r_tx_shift[0];
          r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          r_tx_state <= U_DATA;
        end else r_tx_cnt <= r_tx_cnt + 1'b1;
        U_DATA: if (r_tx_cnt == LP_BIT_LAST) begin
          r_tx_cnt <= '0;
          if (r_tx_bit == 3'd7) begin
            o_uart_tx  <= 1'b1;
            r_tx_state <= U_STOP;
          end else begin
            o_uart_tx  <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_bit   <= r_tx_bit + 3'd1;
          end
        end else r_tx_cnt <= r_tx_cnt + 1'b1;
        U_STOP: if (r_tx_cnt == LP_BIT_LAST) r_tx_state <= U_IDLE;
                else r_tx_cnt <= r_tx_cnt + 1'b1;
        default: r_tx_state <= U_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ib_uart_bridge.sv
// tb/tb_ib_uart_bridge.sv - directed self-checking bench for ib_uart_bridge
// Scenario tasks run in sequence; each compares observed outputs to hand-computed values.

module tb_ib_uart_bridge;
  localparam int CPB = 16;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_uart_rx = 1'b1;
  logic       i_tx_data_ack_n = 1'b1;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_data_available = 1'b0;
  logic       o_uart_tx, o_tx_data_available, o_tx_ack, o_rx_overrun, o_frame_err;
  logic [7:0] o_tx_data;

  int errors = 0;
  int checks = 0;
  int fe_count = 0;
  logic [7:0] bp_bytes [6];

  ib_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_uart_rx(i_uart_rx), .o_uart_tx(o_uart_tx),
    .o_tx_data(o_tx_data), .o_tx_data_available(o_tx_data_available),
    .i_tx_data_ack_n(i_tx_data_ack_n), .i_rx_data(i_rx_data),
    .i_rx_data_available(i_rx_data_available), .o_tx_ack(o_tx_ack),
    .o_rx_overrun(o_rx_overrun), .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_frame_err === 1'b1) fe_count++;

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic host_send(input logic [7:0] b, input logic stop_bit);
    i_uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      i_uart_rx = b[i];
      tick(CPB);
    end
    i_uart_rx = stop_bit;
    tick(CPB);
    i_uart_rx = 1'b1;
  endtask

  task automatic wait_offer(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (o_tx_data_available === 1'b1) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic meter_ack(output int lat, output bit ok);
    i_tx_data_ack_n = 1'b0;
    lat = 0;
    ok  = 1'b0;
    for (int t = 1; t <= 50; t++) begin
      tick(1);
      if (o_tx_data_available === 1'b0) begin lat = t; ok = 1'b1; break; end
    end
  endtask

  task automatic tx_capture(output logic [9:0] bits, output bit ok, output time ts);
    ok = 1'b0;
    bits = '0;
    ts = 0;
    for (int t = 0; t < 3000; t++) begin
      if (o_uart_tx === 1'b0) begin ok = 1'b1; break; end
      tick(1);
    end
    if (ok) begin
      ts = $time;
      tick(CPB / 2);
      bits[0] = o_uart_tx;
      for (int i = 1; i < 10; i++) begin
        tick(CPB);
        bits[i] = o_uart_tx;
      end
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    tick(3);
    i_rst_n = 1'b1;
    tick(2);
    checks++; if (o_uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx: got %b want 1", o_uart_tx); end
    checks++; if (o_tx_data !== 8'hFF) begin errors++; $display("FAIL reset_tx_data: got %h want ff", o_tx_data); end
    checks++; if (o_tx_data_available !== 1'b0) begin errors++; $display("FAIL reset_avail: got %b want 0", o_tx_data_available); end
    checks++; if (o_tx_ack !== 1'b0) begin errors++; $display("FAIL reset_tx_ack: got %b want 0", o_tx_ack); end
    checks++; if (o_rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", o_rx_overrun); end
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", o_frame_err); end
  endtask

  task automatic test_host_to_meter;
    bit ok;
    int lat;
    host_send(8'hA5, 1'b1);
    wait_offer(ok);
    checks++; if (!ok || o_tx_data !== 8'hA5) begin errors++; $display("FAIL h2m_first: got %h avail=%b want a5", o_tx_data, ok); end
    meter_ack(lat, ok);
    checks++; if (!ok || lat != 3) begin errors++; $display("FAIL h2m_ack_latency: got %0d want 3", lat); end
    checks++; if (o_tx_data !== 8'hA5) begin errors++; $display("FAIL h2m_data_hold: got %h want a5", o_tx_data); end
    host_send(8'h5A, 1'b1);
    tick(20);
    checks++; if (o_tx_data_available !== 1'b0) begin errors++; $display("FAIL h2m_no_offer_ack_low: got %b want 0", o_tx_data_available); end
    i_tx_data_ack_n = 1'b1;
    wait_offer(ok);
    checks++; if (!ok || o_tx_data !== 8'h5A) begin errors++; $display("FAIL h2m_second: got %h avail=%b want 5a", o_tx_data, ok); end
    // leave the acknowledge low so the feed side stays stalled for the overrun test
    meter_ack(lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL h2m_second_ack: got timeout want release"); end
  endtask

  task automatic test_overrun;
    bit ok;
    int lat;
    logic [7:0] exp;
    checks++; if (o_rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_initial: got %b want 0", o_rx_overrun); end
    for (int b = 1; b <= 6; b++) host_send(8'(b), 1'b1);
    tick(30);
    checks++; if (o_rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", o_rx_overrun); end
    i_tx_data_ack_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      exp = 8'(k);
      wait_offer(ok);
      checks++; if (!ok || o_tx_data !== exp) begin errors++; $display("FAIL ovr_order_%0d: got %h avail=%b want %h", k, o_tx_data, ok, exp); end
      meter_ack(lat, ok);
      i_tx_data_ack_n = 1'b1;
      tick(2);
    end
    tick(100);
    checks++; if (o_tx_data_available !== 1'b0) begin errors++; $display("FAIL ovr_dropped: got avail=%b data=%h want 0", o_tx_data_available, o_tx_data); end
    checks++; if (o_rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", o_rx_overrun); end
  endtask

  task automatic test_meter_to_host;
    logic [9:0] fr;
    bit ok_c;
    time ts;
    int lat_up, lat_dn;
    lat_up = 0;
    lat_dn = 0;
    fork
      tx_capture(fr, ok_c, ts);
      begin
        i_rx_data = 8'h3C;
        i_rx_data_available = 1'b1;
        for (int t = 1; t <= 20; t++) begin
          tick(1);
          if (o_tx_ack === 1'b1) begin lat_up = t; break; end
        end
        i_rx_data_available = 1'b0;
        for (int t = 1; t <= 20; t++) begin
          tick(1);
          if (o_tx_ack === 1'b0) begin lat_dn = t; break; end
        end
        i_rx_data = 8'h00;
      end
    join
    checks++; if (lat_up != 3) begin errors++; $display("FAIL m2h_ack_rise: got %0d want 3", lat_up); end
    checks++; if (lat_dn != 3) begin errors++; $display("FAIL m2h_ack_fall: got %0d want 3", lat_dn); end
    checks++; if (!ok_c || fr !== 10'b1001111000) begin errors++; $display("FAIL m2h_frame: got %b want 1001111000", fr); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] fr;
    bit ok_c, ok_m;
    time ts, t_start1, t_ack6;
    bp_bytes[0] = 8'h11; bp_bytes[1] = 8'h22; bp_bytes[2] = 8'h33;
    bp_bytes[3] = 8'h44; bp_bytes[4] = 8'h55; bp_bytes[5] = 8'h66;
    t_start1 = 0;
    t_ack6 = 0;
    fork
      for (int k = 0; k < 6; k++) begin
        tx_capture(fr, ok_c, ts);
        if (k == 0) t_start1 = ts;
        checks++; if (!ok_c || fr !== {1'b1, bp_bytes[k], 1'b0}) begin errors++; $display("FAIL bp_frame_%0d: got %b want %b", k, fr, {1'b1, bp_bytes[k], 1'b0}); end
      end
      for (int k = 0; k < 6; k++) begin
        i_rx_data = bp_bytes[k];
        i_rx_data_available = 1'b1;
        if (k == 5) begin
          tick(20);
          checks++; if (o_tx_ack !== 1'b0) begin errors++; $display("FAIL bp_held: got tx_ack=%b want 0", o_tx_ack); end
        end
        ok_m = 1'b0;
        for (int t = 0; t < 1000; t++) begin
          tick(1);
          if (o_tx_ack === 1'b1) begin ok_m = 1'b1; break; end
        end
        if (k == 5) t_ack6 = $time;
        checks++; if (!ok_m) begin errors++; $display("FAIL bp_ack_%0d: got timeout want tx_ack=1", k); end
        i_rx_data_available = 1'b0;
        for (int t = 0; t < 50; t++) begin
          tick(1);
          if (o_tx_ack === 1'b0) break;
        end
      end
    join
    checks++; if (t_ack6 < t_start1 + 158 * 10) begin errors++; $display("FAIL bp_ack_timing: got %0t want >= %0t", t_ack6, t_start1 + 158 * 10); end
  endtask

  task automatic test_line_errors;
    int fe0;
    fe0 = fe_count;
    i_uart_rx = 1'b0;
    tick(4);
    i_uart_rx = 1'b1;
    tick(200);
    checks++; if (fe_count != fe0) begin errors++; $display("FAIL glitch_frame_err: got %0d want %0d", fe_count, fe0); end
    checks++; if (o_tx_data_available !== 1'b0) begin errors++; $display("FAIL glitch_push: got avail=%b want 0", o_tx_data_available); end
    host_send(8'h77, 1'b0);
    tick(40);
    checks++; if (fe_count != fe0 + 1) begin errors++; $display("FAIL stop0_frame_err: got %0d pulses want 1", fe_count - fe0); end
    checks++; if (o_tx_data_available !== 1'b0) begin errors++; $display("FAIL stop0_push: got avail=%b want 0", o_tx_data_available); end
  endtask

  task automatic test_reset_mid_frame;
    bit ok, stale, txlow;
    host_send(8'h12, 1'b1);
    host_send(8'h34, 1'b1);
    tick(5);
    checks++; if (o_tx_data_available !== 1'b1 || o_tx_data !== 8'h12) begin errors++; $display("FAIL rst_pre_offer: got %h avail=%b want 12", o_tx_data, o_tx_data_available); end
    i_rx_data = 8'h81;
    i_rx_data_available = 1'b1;
    tick(4);
    i_rx_data_available = 1'b0;
    tick(4);
    i_uart_rx = 1'b0;
    tick(CPB);
    i_uart_rx = 1'b1;
    tick(2 * CPB);
    i_rst_n = 1'b0;
    tick(1);
    checks++; if (o_uart_tx !== 1'b1) begin errors++; $display("FAIL rst_mid_uart_tx: got %b want 1", o_uart_tx); end
    checks++; if (o_tx_data !== 8'hFF || o_tx_data_available !== 1'b0) begin errors++; $display("FAIL rst_mid_feed: got %h avail=%b want ff/0", o_tx_data, o_tx_data_available); end
    checks++; if (o_tx_ack !== 1'b0 || o_frame_err !== 1'b0) begin errors++; $display("FAIL rst_mid_ack_ferr: got %b/%b want 0/0", o_tx_ack, o_frame_err); end
    checks++; if (o_rx_overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_overrun: got %b want 0", o_rx_overrun); end
    tick(2);
    i_rst_n = 1'b1;
    stale = 1'b0;
    txlow = 1'b0;
    for (int t = 0; t < 300; t++) begin
      tick(1);
      if (o_tx_data_available !== 1'b0) stale = 1'b1;
      if (o_uart_tx !== 1'b1) txlow = 1'b1;
    end
    checks++; if (stale) begin errors++; $display("FAIL rst_stale_offer: got offer %h want none", o_tx_data); end
    checks++; if (txlow) begin errors++; $display("FAIL rst_uart_tx_idle: got activity want idle high"); end
    host_send(8'h5E, 1'b1);
    wait_offer(ok);
    checks++; if (!ok || o_tx_data !== 8'h5E) begin errors++; $display("FAIL rst_fresh_byte: got %h avail=%b want 5e", o_tx_data, ok); end
  endtask

  initial begin
    test_reset();
    test_host_to_meter();
    test_overrun();
    test_meter_to_host();
    test_back_to_back();
    test_line_errors();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish before 2ms");
    $fatal(1, "timeout");
  end
endmodule
